// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder: packs decoded fields into 32-bit words
// and writes them sequentially into instruction memory during program load.
module inst_encoder #(
  parameter int unsigned RFW = 5,
  parameter int unsigned DW  = 32,
  parameter int unsigned IW  = 32,
  parameter int unsigned AW  = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           finish,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     fmt,
  input  logic [4:0]     opcode,
  input  logic [2:0]     funct3,
  input  logic [6:0]     funct7,
  input  logic [RFW-1:0] rd,
  input  logic [RFW-1:0] rs1,
  input  logic [RFW-1:0] rs2,
  input  logic [DW-1:0]  imm,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [IW-1:0]  mem_wdata,
  output logic           busy,
  output logic           full,
  output logic           err,
  output logic [AW:0]    count
);

  typedef enum logic [1:0] {StIdle, StRun, StFull} state_e;

  localparam logic [AW-1:0] LastAddr  = '1;
  localparam logic [AW:0]   LastCount = {1'b0, LastAddr};

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [IW-1:0] wdata_q, wdata_d;

  logic [4:0]        rd_f, rs1_f, rs2_f;
  logic signed [31:0] imm_x;
  logic [31:0]       enc;
  logic              legal;
  logic              accept, wr_ok, at_last;
  logic [AW:0]       count_base;

  assign rd_f  = 5'(rd);
  assign rs1_f = 5'(rs1);
  assign rs2_f = 5'(rs2);
  // Sign-extend the immediate so range checks work on its numeric value.
  assign imm_x = 32'(signed'(imm));

  // Format-specific bit scattering and immediate range checks.
  always_comb begin
    enc   = '0;
    legal = 1'b0;
    case (fmt)
      3'd0: begin
        enc   = {funct7, rs2_f, rs1_f, funct3, rd_f, opcode, 2'b11};
        legal = 1'b1;
      end
      3'd1: begin
        enc   = {imm_x[11:0], rs1_f, funct3, rd_f, opcode, 2'b11};
        legal = (imm_x >= -32'sd2048) && (imm_x <= 32'sd2047);
      end
      3'd2: begin
        enc   = {imm_x[11:5], rs2_f, rs1_f, funct3, imm_x[4:0], opcode, 2'b11};
        legal = (imm_x >= -32'sd2048) && (imm_x <= 32'sd2047);
      end
      3'd3: begin
        enc   = {imm_x[12], imm_x[10:5], rs2_f, rs1_f, funct3, imm_x[4:1], imm_x[11],
                 opcode, 2'b11};
        legal = (imm_x >= -32'sd4096) && (imm_x <= 32'sd4094) && !imm_x[0];
      end
      3'd4: begin
        enc   = {imm_x[31:12], rd_f, opcode, 2'b11};
        legal = (imm_x[11:0] == 12'h000);
      end
      3'd5: begin
        enc   = {imm_x[20], imm_x[10:1], imm_x[11], imm_x[19:12], rd_f, opcode, 2'b11};
        legal = (imm_x >= -32'sd1048576) && (imm_x <= 32'sd1048574) && !imm_x[0];
      end
      default: begin
        enc   = '0;
        legal = 1'b0;
      end
    endcase
  end

  assign in_ready = (state_q == StRun);
  assign accept   = in_valid && in_ready;
  assign wr_ok    = accept && legal;
  // A restart in RUN with a bundle present counts that bundle into the new session.
  assign count_base = start ? '0 : count_q;
  // The bundle taking the last free slot closes the door before its write lands.
  assign at_last    = wr_ok && (count_base == LastCount);

  // Next-state logic for the session FSM and datapath registers.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = wr_ok;
    wdata_d = wdata_q;

    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun: begin
        if (start)       state_d = at_last ? StFull : StRun;
        else if (finish) state_d = StIdle;
        else if (at_last) state_d = StFull;
      end
      StFull: begin
        if (start)       state_d = StRun;
        else if (finish) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Address advances after each write lands and saturates at the top.
    if (start) begin
      addr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else if (we_q && (addr_q != LastAddr)) begin
      addr_d = addr_q + 1'b1;
    end

    if (wr_ok) begin
      count_d = count_base + 1'b1;
      wdata_d = IW'(enc);
    end
    if (accept && !legal) err_d = 1'b1;
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != StIdle) || we_q;
  assign full      = (state_q == StFull);
  assign err       = err_q;
  assign count     = count_q;

endmodule
